// File: rtl/gpr_read_scoreboard_if.sv
// gpr_read_scoreboard_if: decode read/issue and writeback bundle for the GPR read scoreboard
interface gpr_read_scoreboard_if #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = 5
);
   logic                 rd_use1;
   logic [ADDR_SIZE-1:0] rd_addr1;
   logic [DATA_SIZE-1:0] rd_data1;
   logic                 rd_use2;
   logic [ADDR_SIZE-1:0] rd_addr2;
   logic [DATA_SIZE-1:0] rd_data2;
   logic                 issue_valid;
   logic [ADDR_SIZE-1:0] issue_dst;
   logic                 stall;
   logic                 wb_enable;
   logic [ADDR_SIZE-1:0] wb_addr;
   logic [DATA_SIZE-1:0] wb_data;
   logic                 sb_error;
   modport master (
      output rd_use1, rd_addr1, rd_use2, rd_addr2, issue_valid, issue_dst, wb_enable, wb_addr, wb_data,
      input  rd_data1, rd_data2, stall, sb_error
   );
   modport slave (
      input  rd_use1, rd_addr1, rd_use2, rd_addr2, issue_valid, issue_dst, wb_enable, wb_addr, wb_data,
      output rd_data1, rd_data2, stall, sb_error
   );
endinterface

// File: rtl/gpr_read_scoreboard.sv
// gpr_read_scoreboard: 32-entry GPR file with write-through reads and a per-register pending-write scoreboard
module gpr_read_scoreboard #(
   parameter int DATA_SIZE    = 32,
   parameter int ADDR_SIZE    = 5,
   parameter int MAX_INFLIGHT = 3
) (
   input logic clk,
   input logic reset,
   gpr_read_scoreboard_if.slave bus
);
   localparam int NREG = 1 << ADDR_SIZE;
   localparam int CW   = $clog2(MAX_INFLIGHT + 1);
   logic [DATA_SIZE-1:0] regs_q [NREG];
   logic [DATA_SIZE-1:0] regs_d [NREG];
   logic [CW-1:0]        cnt_q  [NREG];
   logic [CW-1:0]        cnt_d  [NREG];
   logic sb_error_q, sb_error_d;
   logic wb_hit, dec, issue_ok, hazard1, hazard2, full;
   always_comb begin
      wb_hit   = bus.wb_enable && bus.wb_addr != '0;
      // the last pending write retiring this cycle is forwarded, so it does not hazard
      hazard1  = bus.rd_use1 && bus.rd_addr1 != '0 && cnt_q[bus.rd_addr1] != '0
                 && !(cnt_q[bus.rd_addr1] == CW'(1) && bus.wb_enable && bus.wb_addr == bus.rd_addr1);
      hazard2  = bus.rd_use2 && bus.rd_addr2 != '0 && cnt_q[bus.rd_addr2] != '0
                 && !(cnt_q[bus.rd_addr2] == CW'(1) && bus.wb_enable && bus.wb_addr == bus.rd_addr2);
      full     = bus.issue_valid && bus.issue_dst != '0 && cnt_q[bus.issue_dst] == CW'(MAX_INFLIGHT)
                 && !(bus.wb_enable && bus.wb_addr == bus.issue_dst);
      bus.stall = hazard1 | hazard2 | full;
      issue_ok = bus.issue_valid && !bus.stall && bus.issue_dst != '0;
      dec      = wb_hit && cnt_q[bus.wb_addr] != '0;
      bus.rd_data1 = bus.rd_addr1 == '0 ? '0
                   : (bus.wb_enable && bus.wb_addr == bus.rd_addr1) ? bus.wb_data : regs_q[bus.rd_addr1];
      bus.rd_data2 = bus.rd_addr2 == '0 ? '0
                   : (bus.wb_enable && bus.wb_addr == bus.rd_addr2) ? bus.wb_data : regs_q[bus.rd_addr2];
      bus.sb_error = sb_error_q;
      regs_d     = regs_q;
      cnt_d      = cnt_q;
      sb_error_d = sb_error_q | (wb_hit && !dec);
      if (wb_hit) regs_d[bus.wb_addr] = bus.wb_data;
      if (issue_ok && !(dec && bus.wb_addr == bus.issue_dst)) cnt_d[bus.issue_dst] = cnt_q[bus.issue_dst] + CW'(1);
      if (dec && !(issue_ok && bus.wb_addr == bus.issue_dst)) cnt_d[bus.wb_addr] = cnt_q[bus.wb_addr] - CW'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q     <= '{default: '0};
         cnt_q      <= '{default: '0};
         sb_error_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         cnt_q      <= cnt_d;
         sb_error_q <= sb_error_d;
      end
   end
endmodule

// File: tb/tb_gpr_read_scoreboard.sv
// tb_gpr_read_scoreboard: per-cycle vector table with a queue of expected outputs
module tb_gpr_read_scoreboard;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   gpr_read_scoreboard_if #(.DATA_SIZE(32), .ADDR_SIZE(5)) bus ();
   gpr_read_scoreboard #(.DATA_SIZE(32), .ADDR_SIZE(5), .MAX_INFLIGHT(3)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   typedef struct {
      logic        rst, u1; logic [4:0] a1;
      logic        u2;      logic [4:0] a2;
      logic        iv;      logic [4:0] dst;
      logic        we;      logic [4:0] wa; logic [31:0] wd;
      logic [31:0] d1, d2;
      logic        st, err, chk;
   } vec_t;
   typedef struct {
      int          row;
      logic [31:0] d1, d2;
      logic        st, err;
   } exp_t;
   vec_t tv[$];
   exp_t sbq[$];
   int checks = 0;
   int failures = 0;
   function automatic vec_t mk(int rst, int u1, int a1, int u2, int a2, int iv, int dst,
                               int we, int wa, logic [31:0] wd, logic [31:0] d1, logic [31:0] d2,
                               int st, int err, int chk);
      vec_t v;
      v.rst = rst[0]; v.u1 = u1[0]; v.a1 = 5'(a1); v.u2 = u2[0]; v.a2 = 5'(a2);
      v.iv = iv[0]; v.dst = 5'(dst); v.we = we[0]; v.wa = 5'(wa); v.wd = wd;
      v.d1 = d1; v.d2 = d2; v.st = st[0]; v.err = err[0]; v.chk = chk[0];
      return v;
   endfunction
   task automatic cmp(string nm, int row, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
      end
   endtask
   task automatic apply(vec_t v, int row);
      exp_t e;
      reset           = v.rst;
      bus.rd_use1     = v.u1;  bus.rd_addr1  = v.a1;
      bus.rd_use2     = v.u2;  bus.rd_addr2  = v.a2;
      bus.issue_valid = v.iv;  bus.issue_dst = v.dst;
      bus.wb_enable   = v.we;  bus.wb_addr   = v.wa;  bus.wb_data = v.wd;
      if (v.chk) sbq.push_back('{row, v.d1, v.d2, v.st, v.err});
      #3;
      if (v.chk) begin
         e = sbq.pop_front();
         cmp("rd_data1", e.row, bus.rd_data1, e.d1);
         cmp("rd_data2", e.row, bus.rd_data2, e.d2);
         cmp("stall",    e.row, 32'(bus.stall), 32'(e.st));
         cmp("sb_error", e.row, 32'(bus.sb_error), 32'(e.err));
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 1'b1;
      bus.rd_use1 = 0; bus.rd_addr1 = 0; bus.rd_use2 = 0; bus.rd_addr2 = 0;
      bus.issue_valid = 0; bus.issue_dst = 0; bus.wb_enable = 0; bus.wb_addr = 0; bus.wb_data = 0;
      @(posedge clk);
      #1;
      // rst u1 a1 u2 a2 iv dst we wa wd | d1 d2 st err chk
      tv.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
      tv.push_back(mk(0,0,5,0,31,0,0,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,5,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,1,5,0,0,0,0,0,0,0, 0,0,1,0,1));
      tv.push_back(mk(0,1,5,0,0,0,0,1,5,32'hDEADBEEF, 32'hDEADBEEF,0,0,0,1));
      tv.push_back(mk(0,1,5,0,0,1,7,0,0,0, 32'hDEADBEEF,0,0,0,1));
      tv.push_back(mk(0,1,5,1,7,0,0,1,7,32'h12345678, 32'hDEADBEEF,32'h12345678,0,0,1));
      tv.push_back(mk(0,0,5,0,7,0,0,0,0,0, 32'hDEADBEEF,32'h12345678,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,3,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,1,3,0,0,0,0,0,0,0, 0,0,1,0,1));
      tv.push_back(mk(0,1,3,0,0,1,10,0,0,0, 0,0,1,0,1));
      tv.push_back(mk(0,1,3,0,0,0,0,1,3,32'hA5, 32'hA5,0,0,0,1));
      tv.push_back(mk(0,1,3,1,10,0,0,0,0,0, 32'hA5,0,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,4,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,4,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,4,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,4,0,0,0, 0,0,1,0,1));
      tv.push_back(mk(0,0,4,0,0,1,4,1,4,32'h44, 32'h44,0,0,0,1));
      tv.push_back(mk(0,0,4,0,0,1,4,0,0,0, 32'h44,0,1,0,1));
      tv.push_back(mk(0,1,4,0,0,0,0,1,4,32'h45, 32'h45,0,1,0,1));
      tv.push_back(mk(0,1,4,0,0,0,0,1,4,32'h46, 32'h46,0,1,0,1));
      tv.push_back(mk(0,1,4,0,0,0,0,1,4,32'h47, 32'h47,0,0,0,1));
      tv.push_back(mk(0,1,4,0,0,0,0,0,0,0, 32'h47,0,0,0,1));
      tv.push_back(mk(0,0,9,0,0,0,0,1,9,32'h99, 32'h99,0,0,0,1));
      tv.push_back(mk(0,0,9,0,0,0,0,0,0,0, 32'h99,0,0,1,1));
      tv.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,1,1));
      tv.push_back(mk(0,1,0,1,0,1,0,1,0,32'hFFFFFFFF, 0,0,0,1,1));
      tv.push_back(mk(0,1,0,1,0,1,0,0,0,0, 0,0,0,1,1));
      tv.push_back(mk(0,0,0,0,0,1,12,0,0,0, 0,0,0,1,1));
      tv.push_back(mk(0,1,12,0,0,0,0,0,0,0, 0,0,1,1,1));
      tv.push_back(mk(1,1,12,0,0,1,14,1,13,32'h77, 0,0,0,0,0));
      tv.push_back(mk(0,1,12,1,5,0,0,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,1,13,1,14,0,0,0,0,0, 0,0,0,0,1));
      tv.push_back(mk(0,1,3,1,7,0,0,0,0,0, 0,0,0,0,1));
      foreach (tv[i]) apply(tv[i], i);
      apply(mk(0,0,20,0,0,0,0,1,20,32'h20, 32'h20,0,0,0,1), 100);
      for (int k = 0; k < 6; k++) apply(mk(0,0,20,1,9,0,0,0,0,0, 32'h20,0,0,1,1), 101 + k);
      apply(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0), 110);
      apply(mk(0,1,20,1,9,1,6,0,0,0, 0,0,0,0,1), 111);
      apply(mk(0,1,6,0,0,0,0,0,0,0, 0,0,1,0,1), 112);
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain leftover=%0d expected=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
